// File: rtl/kbd_port_pkg.sv
// Shared definitions for the keyboard receive port: register offsets,
// STATUS bit layout, interrupt FSM states and a pointer-width helper.
package kbd_port_pkg;

    localparam logic [63:0] OFF_DATA    = 64'd0;
    localparam logic [63:0] OFF_STATUS  = 64'd8;
    localparam logic [63:0] OFF_CONTROL = 64'd16;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERFLOW  = 2;
    localparam int STATUS_COUNT_LSB = 8;

    localparam int CONTROL_IE = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } irq_state_t;

    // Number of bits needed to address 'value' entries (minimum 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and a separate occupancy count;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo
    import kbd_port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/kbd_fifo_port.sv
// Bus-mapped keyboard receive port: buffers decoder bytes and exposes
// DATA/STATUS/CONTROL registers plus a handshaked interrupt vector.
module kbd_fifo_port
    import kbd_port_pkg::*;
#(
    parameter int          DEPTH  = 8,
    parameter logic [63:0] BASE   = 64'h8000_0010,
    parameter logic [3:0]  VECTOR = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_ascii,
    input  logic [63:0] bus_address,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    input  logic [63:0] bus_write_data,
    output logic [63:0] bus_read_data,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_done,
    output logic [6:0]  fifo_count
);

    localparam int          CNT_W        = clog2(DEPTH) + 1;
    localparam logic [63:0] DATA_ADDR    = BASE + OFF_DATA;
    localparam logic [63:0] STATUS_ADDR  = BASE + OFF_STATUS;
    localparam logic [63:0] CONTROL_ADDR = BASE + OFF_CONTROL;

    logic             sel_data;
    logic             sel_status;
    logic             sel_control;
    logic             pop_req;
    logic [7:0]       head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             ie;
    logic [63:0]      status_word;
    irq_state_t       irq_state;
    irq_state_t       irq_next;
    logic             unused_write_bits;

    assign sel_data    = (bus_address == DATA_ADDR);
    assign sel_status  = (bus_address == STATUS_ADDR);
    assign sel_control = (bus_address == CONTROL_ADDR);
    assign pop_req     = bus_read_enable && sel_data && !empty;
    assign fifo_count  = 7'(count);

    assign unused_write_bits = ^{bus_write_data[63:3], bus_write_data[1]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (key_valid),
        .pop   (pop_req),
        .din   (key_ascii),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        status_word                              = '0;
        status_word[STATUS_COUNT_LSB +: 8]       = 8'(count);
        status_word[STATUS_OVERFLOW]             = overflow;
        status_word[STATUS_FULL]                 = full;
        status_word[STATUS_EMPTY]                = empty;
    end

    // A dropped byte outranks a same-cycle clear so no loss goes unreported.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
            ie       <= 1'b0;
        end else begin
            if (key_valid && full && !pop_req) begin
                overflow <= 1'b1;
            end else if (bus_write_enable && sel_status && bus_write_data[STATUS_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            if (bus_write_enable && sel_control) begin
                ie <= bus_write_data[CONTROL_IE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_read_data <= '0;
        end else if (bus_read_enable) begin
            if (sel_data) begin
                bus_read_data <= empty ? 64'd0 : {55'd0, 1'b1, head};
            end else if (sel_status) begin
                bus_read_data <= status_word;
            end else if (sel_control) begin
                bus_read_data <= {63'd0, ie};
            end
        end
    end

    always_comb begin
        irq_next = irq_state;
        unique case (irq_state)
            IDLE:    if (ie && !empty) irq_next = PEND;
            PEND:    if (interrupt_done) irq_next = ACK;
                     else if (!ie) irq_next = IDLE;
            ACK:     if (!interrupt_done) irq_next = IDLE;
            default: irq_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_state        <= IDLE;
            interrupt_vector <= 4'd0;
        end else begin
            irq_state        <= irq_next;
            interrupt_vector <= (irq_next == PEND) ? VECTOR : 4'd0;
        end
    end

endmodule
